// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 INCR-burst slave backed by a byte-writable synchronous RAM
module axi_ram_slave #(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 16,
  parameter int LEN_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                axi_awid,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [LEN_W-1:0]    axi_awlen,
  input  logic [2:0]          axi_awsize,
  input  logic [1:0]          axi_awburst,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wlast,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  output logic                axi_bid,
  output logic [1:0]          axi_bresp,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  input  logic                axi_arid,
  input  logic [ADDR_W-1:0]   axi_araddr,
  input  logic [LEN_W-1:0]    axi_arlen,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  output logic                axi_rid,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rlast,
  output logic                axi_rvalid,
  input  logic                axi_rready
);
  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {W_INIT, W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA} r_state_t;

  logic [DATA_W-1:0] mem [2**MEM_ADDR_W];

  w_state_t              w_state, w_next;
  logic [MEM_ADDR_W-1:0] w_idx;
  logic [LEN_W-1:0]      w_len, w_cnt;
  logic                  w_id, w_err, w_fire, w_last_beat;

  r_state_t              r_state, r_next;
  logic [MEM_ADDR_W-1:0] r_idx, rd_idx;
  logic [LEN_W-1:0]      r_len, r_cnt;
  logic                  r_id, r_done, iss, iss_last, pop, free;
  logic                  ram_v, ram_last, skid_v, skid_last, rvalid_q, rlast_q;
  logic [DATA_W-1:0]     ram_q, skid_q, rdata_q;
  logic [1:0]            occ;

  // Size/burst are fixed by construction and address bits outside the RAM window alias.
  logic unused_bits;
  assign unused_bits = ^{axi_awsize, axi_awburst, axi_awaddr, axi_araddr};

  // Write FSM state register; W_INIT holds readies low for one edge after reset.
  always_ff @(posedge clk or posedge rst)
    if (rst) w_state <= W_INIT;
    else     w_state <= w_next;

  // Write FSM next state and Moore-style channel handshakes.
  always_comb begin
    w_next      = w_state;
    axi_awready = w_state == W_IDLE;
    axi_wready  = w_state == W_DATA;
    axi_bvalid  = w_state == W_RESP;
    axi_bid     = w_id;
    axi_bresp   = {axi_bvalid && w_err, 1'b0};
    w_fire      = axi_wvalid && axi_wready;
    w_last_beat = w_cnt == w_len;
    case (w_state)
      W_INIT:  w_next = W_IDLE;
      W_IDLE:  w_next = axi_awvalid ? W_DATA : W_IDLE;
      W_DATA:  w_next = (w_fire && w_last_beat) ? W_RESP : W_DATA;
      W_RESP:  w_next = axi_bready ? W_IDLE : W_RESP;
      default: w_next = W_INIT;
    endcase
  end

  // Write burst bookkeeping; the counter saturates at len so len=255 cannot wrap.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_id  <= 1'b0;
      w_err <= 1'b0;
    end else if (axi_awvalid && axi_awready) begin
      w_idx <= axi_awaddr[MEM_ADDR_W+1:2];
      w_len <= axi_awlen;
      w_cnt <= '0;
      w_id  <= axi_awid;
      w_err <= 1'b0;
    end else if (w_fire) begin
      w_idx <= w_idx + MEM_ADDR_W'(1);
      w_cnt <= w_last_beat ? w_cnt : w_cnt + LEN_W'(1);
      w_err <= w_err | (axi_wlast != w_last_beat);
    end

  // RAM: byte-masked write and read-first synchronous read on the same edge.
  always_ff @(posedge clk) begin
    if (iss) ram_q <= mem[rd_idx];
    for (int b = 0; b < NB; b++)
      if (w_fire && axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= axi_wdata[b*8 +: 8];
  end

  // Read FSM state register; R_INIT holds arready low for one edge after reset.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= R_INIT;
    else     r_state <= r_next;

  // Read FSM next state and issue control: a RAM read is launched only when the
  // output register plus skid register can absorb it even if rready stays low.
  always_comb begin
    r_next      = r_state;
    axi_arready = r_state == R_IDLE;
    pop         = rvalid_q && axi_rready;
    free        = !rvalid_q || pop;
    occ         = 2'(rvalid_q && !pop) + 2'(skid_v) + 2'(ram_v);
    iss         = axi_arready ? axi_arvalid : (r_state == R_DATA && !r_done && occ <= 2'd1);
    iss_last    = axi_arready ? axi_arlen == '0 : r_cnt == r_len;
    rd_idx      = axi_arready ? axi_araddr[MEM_ADDR_W+1:2] : r_idx;
    case (r_state)
      R_INIT:  r_next = R_IDLE;
      R_IDLE:  r_next = axi_arvalid ? R_DATA : R_IDLE;
      R_DATA:  r_next = (pop && rlast_q) ? R_IDLE : R_DATA;
      default: r_next = R_INIT;
    endcase
  end

  // Read issue counters, RAM pipeline tag and the output/skid pair.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_idx     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_id      <= 1'b0;
      r_done    <= 1'b0;
      ram_v     <= 1'b0;
      ram_last  <= 1'b0;
      skid_v    <= 1'b0;
      skid_last <= 1'b0;
      skid_q    <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (iss) begin
        r_idx  <= rd_idx + MEM_ADDR_W'(1);
        r_cnt  <= axi_arready ? LEN_W'(1) : (iss_last ? r_cnt : r_cnt + LEN_W'(1));
        r_done <= iss_last;
      end
      if (axi_arvalid && axi_arready) begin
        r_len <= axi_arlen;
        r_id  <= axi_arid;
      end
      ram_v    <= iss;
      ram_last <= iss && iss_last;
      if (free && skid_v) begin
        rvalid_q  <= 1'b1;
        rdata_q   <= skid_q;
        rlast_q   <= skid_last;
        skid_v    <= ram_v;
        skid_q    <= ram_q;
        skid_last <= ram_last;
      end else if (free) begin
        rvalid_q <= ram_v;
        rlast_q  <= ram_last;
        rdata_q  <= ram_v ? ram_q : rdata_q;
      end else if (ram_v) begin
        skid_v    <= 1'b1;
        skid_q    <= ram_q;
        skid_last <= ram_last;
      end
    end

  assign axi_rvalid = rvalid_q;
  assign axi_rdata  = rdata_q;
  assign axi_rlast  = rlast_q;
  assign axi_rid    = r_id;
  assign axi_rresp  = 2'b00;
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: randomized scoreboard bench for axi_ram_slave against a word-array model
module tb_axi_ram_slave;
  logic        clk = 0;
  logic        rst = 1;
  logic        axi_awid, axi_awvalid, axi_awready;
  logic [29:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast, axi_wvalid, axi_wready;
  logic        axi_bid, axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;
  logic        axi_arid, axi_arvalid, axi_arready;
  logic [29:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic        axi_rid, axi_rlast, axi_rvalid, axi_rready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;

  always #5 clk = ~clk;

  axi_ram_slave dut (
    .clk(clk), .rst(rst),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  typedef struct packed {logic [31:0] d; logic l; logic id;} rexp_t;
  typedef struct packed {logic [1:0] resp; logic id;} bexp_t;

  rexp_t       rq[$];
  bexp_t       bq[$];
  rexp_t       re;
  bexp_t       be;
  logic [31:0] mdl [65536];
  logic [31:0] wq_d[$];
  logic [3:0]  wq_s[$];
  logic        wq_l[$];
  int          total = 0, bad = 0, rmode = 0, pc = 0;
  logic        pst = 0, pid, plast;
  logic [31:0] pdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  function automatic logic [15:0] widx(input logic [29:0] a, input int i);
    return 16'(int'(a >> 2) + i);
  endfunction

  task automatic rd_expect(input logic [29:0] a, input int len, input logic id);
    rexp_t e;
    for (int i = 0; i <= len; i++) begin
      e.d  = mdl[widx(a, i)];
      e.l  = (i == len);
      e.id = id;
      rq.push_back(e);
    end
  endtask

  task automatic wr_model(input logic [29:0] a, input int len, input logic id);
    logic  err;
    bexp_t e;
    err = 0;
    for (int i = 0; i <= len; i++) begin
      for (int b = 0; b < 4; b++)
        if (wq_s[i][b]) mdl[widx(a, i)][b*8 +: 8] = wq_d[i][b*8 +: 8];
      err = err | (wq_l[i] != (i == len));
    end
    e.resp = err ? 2'b10 : 2'b00;
    e.id   = id;
    bq.push_back(e);
  endtask

  task automatic wq_build(input int n, input int lastbeat, input logic rnd_strb);
    wq_d.delete();
    wq_s.delete();
    wq_l.delete();
    for (int i = 0; i < n; i++) begin
      wq_d.push_back($urandom);
      wq_s.push_back(rnd_strb ? 4'($urandom) : 4'hF);
      wq_l.push_back(i == lastbeat);
    end
  endtask

  task automatic aw_drive(input logic [29:0] a, input int len, input logic id);
    int n = 0;
    axi_awaddr = a; axi_awlen = 8'(len); axi_awid = id; axi_awvalid = 1;
    @(negedge clk);
    while (!axi_awready && n < 600) begin @(negedge clk); n++; end
    if (!axi_awready) tmo("aw_handshake");
    @(posedge clk); #1;
    axi_awvalid = 0;
  endtask

  task automatic w_drive();
    int n;
    for (int i = 0; i < wq_d.size(); i++) begin
      axi_wdata = wq_d[i]; axi_wstrb = wq_s[i]; axi_wlast = wq_l[i]; axi_wvalid = 1;
      n = 0;
      @(negedge clk);
      while (!axi_wready && n < 600) begin @(negedge clk); n++; end
      if (!axi_wready) begin tmo("w_handshake"); break; end
      @(posedge clk); #1;
    end
    axi_wvalid = 0; axi_wlast = 0;
    @(negedge clk);
    chk("wready_after_last", 64'(axi_wready), 0);
    @(posedge clk); #1;
  endtask

  task automatic ar_drive(input logic [29:0] a, input int len, input logic id);
    int n = 0;
    axi_araddr = a; axi_arlen = 8'(len); axi_arid = id; axi_arvalid = 1;
    @(negedge clk);
    while (!axi_arready && n < 600) begin @(negedge clk); n++; end
    if (!axi_arready) tmo("ar_handshake");
    @(posedge clk); #1;
    axi_arvalid = 0;
    @(negedge clk);
    chk("rvalid_at_n1", 64'(axi_rvalid), 0);
    @(negedge clk);
    chk("rvalid_at_n2", 64'(axi_rvalid), 1);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [29:0] a, input int len, input logic id);
    wr_model(a, len, id);
    aw_drive(a, len, id);
    w_drive();
  endtask

  task automatic do_read(input logic [29:0] a, input int len, input logic id);
    rd_expect(a, len, id);
    ar_drive(a, len, id);
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 5000) begin @(negedge clk); n++; end
    if (rq.size() != 0 || bq.size() != 0) tmo("drain");
    @(posedge clk); #1;
  endtask

  // Master-side readiness for R and B, changed just after each clock edge.
  always @(posedge clk) begin
    #1;
    pc++;
    axi_rready = (rmode == 0) || (rmode == 1 && $urandom % 2 == 1) || (rmode == 2 && pc % 3 == 0);
    axi_bready = (rmode != 1) || ($urandom % 3 != 0);
  end

  // Monitor: pops the scoreboard on every R/B handshake and checks stall stability.
  always @(negedge clk) begin
    if (rst) pst = 0;
    else begin
      if (pst) chk("r_hold_stable", {axi_rvalid, axi_rid, axi_rlast, axi_rdata}, {1'b1, pid, plast, pdata});
      if (axi_rvalid && axi_rready) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL r_unexpected: got=%0h want=none", axi_rdata);
        end else begin
          re = rq.pop_front();
          chk("rdata", 64'(axi_rdata), 64'(re.d));
          chk("rlast", 64'(axi_rlast), 64'(re.l));
          chk("rid", 64'(axi_rid), 64'(re.id));
          chk("rresp", 64'(axi_rresp), 0);
        end
      end
      if (axi_bvalid && axi_bready) begin
        if (bq.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected: got=%0h want=none", axi_bresp);
        end else begin
          be = bq.pop_front();
          chk("bresp", 64'(axi_bresp), 64'(be.resp));
          chk("bid", 64'(axi_bid), 64'(be.id));
        end
      end
      pst   = axi_rvalid && !axi_rready;
      pid   = axi_rid;
      plast = axi_rlast;
      pdata = axi_rdata;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1);
  end

  initial begin
    int len, idx;
    logic [29:0] a;
    axi_awid = 0; axi_awaddr = 0; axi_awlen = 0; axi_awsize = 3'd2; axi_awburst = 2'b01; axi_awvalid = 0;
    axi_wdata = 0; axi_wstrb = 0; axi_wlast = 0; axi_wvalid = 0;
    axi_arid = 0; axi_araddr = 0; axi_arlen = 0; axi_arvalid = 0;
    axi_rready = 1; axi_bready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rlast, axi_bresp, axi_bid, axi_rid}, 0);
    chk("reset_rdata", 64'(axi_rdata), 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("ready_before_edge", {axi_awready, axi_arready}, 0);
    @(negedge clk);
    chk("ready_after_edge", {axi_awready, axi_arready}, 2'b11);
    @(posedge clk); #1;

    // Fill words 0..255 with a full 256-beat burst, read it back with random stalls.
    wq_build(256, 255, 0);
    do_write(30'h0, 255, 0);
    drain();
    rmode = 1;
    do_read(30'h0, 255, 0);
    drain();

    // Four-beat write/read of known data.
    rmode = 0;
    wq_d.delete(); wq_s.delete(); wq_l.delete();
    for (int i = 0; i < 4; i++) begin
      wq_d.push_back(32'h11111111 * 32'(i + 1));
      wq_s.push_back(4'hF);
      wq_l.push_back(i == 3);
    end
    do_write(30'h100, 3, 1);
    drain();
    do_read(30'h100, 3, 1);
    drain();

    // Byte strobes merge into an existing word.
    wq_d.delete(); wq_s.delete(); wq_l.delete();
    wq_d.push_back(32'h12345678); wq_s.push_back(4'hF); wq_l.push_back(1);
    do_write(30'h200, 0, 0);
    wq_d.delete(); wq_s.delete(); wq_l.delete();
    wq_d.push_back(32'hAABBCCDD); wq_s.push_back(4'b0101); wq_l.push_back(1);
    do_write(30'h200, 0, 1);
    drain();
    do_read(30'h200, 0, 1);
    drain();

    // Eight beats under a 1,0,0 rready pattern.
    rmode = 2;
    do_read(30'h0, 7, 1);
    drain();

    // Early wlast on a two-beat burst.
    rmode = 0;
    wq_build(2, 0, 0);
    do_write(30'h300, 1, 1);
    drain();
    do_read(30'h300, 1, 0);
    drain();

    // Burst wrapping past the top of the RAM, with aliased upper address bits.
    wq_build(4, 3, 0);
    do_write(30'h103FFF8, 3, 0);
    drain();
    do_read(30'h003FFF8, 3, 1);
    drain();
    do_read(30'h0, 1, 0);
    drain();

    // Randomized traffic within the initialised region.
    rmode = 1;
    for (int k = 0; k < 24; k++) begin
      len = $urandom_range(0, 15);
      idx = $urandom_range(0, 255 - len);
      a   = ($urandom & 30'h3FFC0000) | 30'(idx << 2) | 30'($urandom % 4);
      if ($urandom % 2 == 1) begin
        wq_build(len + 1, ($urandom % 5 == 0) ? $urandom_range(0, len) : len, 1);
        do_write(a, len, 1'($urandom));
      end else do_read(a, len, 1'($urandom));
      drain();
    end

    // Same-cycle read and write bursts on the same words return the old data.
    rmode = 0;
    wq_build(4, 3, 0);
    rd_expect(30'h40, 3, 0);
    wr_model(30'h40, 3, 1);
    fork
      ar_drive(30'h40, 3, 0);
      begin
        aw_drive(30'h40, 3, 1);
        w_drive();
      end
    join
    drain();
    do_read(30'h40, 3, 1);
    drain();

    // Reset in the middle of a stalled read.
    rmode = 2;
    do_read(30'h0, 15, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("midreset_outputs", {axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rlast}, 0);
    rq.delete();
    bq.delete();
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("post_reset_ready_pre", {axi_awready, axi_arready}, 0);
    chk("post_reset_idle", {axi_rvalid, axi_bvalid, axi_wready}, 0);
    @(negedge clk);
    chk("post_reset_ready", {axi_awready, axi_arready}, 2'b11);
    chk("post_reset_idle2", {axi_rvalid, axi_bvalid, axi_wready}, 0);
    @(posedge clk); #1;
    rmode = 0;
    wq_build(3, 2, 1);
    do_write(30'h80, 2, 0);
    drain();
    do_read(30'h80, 2, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
